// File: rtl/seg7_capture_if.sv
// Digit output port of seg7_capture: FWFT head digit with valid/ready handshake.
interface seg7_capture_if;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_digit;

   modport master (output out_valid, output out_digit, input out_ready);
   modport slave  (input out_valid, input out_digit, output out_ready);
endinterface

// File: rtl/seg7_capture.sv
// 7-segment receive monitor: glitch filter, glyph-to-hex decode, digit FIFO
// and saturating illegal-glyph counter.
module seg7_capture #(
   parameter int STABLE_CYCLES = 3,
   parameter int FIFO_DEPTH    = 4,
   parameter int ERR_CNT_W     = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [0:6]                  seg_in,
   seg7_capture_if.master              dig,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        err_pulse,
   output logic [ERR_CNT_W-1:0]        err_count,
   output logic                        overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(STABLE_CYCLES);
   localparam logic [LVL_W-1:0]     LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // Returns {legal, digit}; blank and unknown patterns both come back as not legal.
   function automatic logic [4:0] decode_glyph(input logic [0:6] g);
      logic [4:0] r;
      case (g)
         7'b1111110: r = 5'h10;
         7'b0110000: r = 5'h11;
         7'b1101101: r = 5'h12;
         7'b1111001: r = 5'h13;
         7'b0110011: r = 5'h14;
         7'b1011011: r = 5'h15;
         7'b1011111: r = 5'h16;
         7'b1110000: r = 5'h17;
         7'b1111111: r = 5'h18;
         7'b1111011: r = 5'h19;
         7'b1110111: r = 5'h1A;
         7'b0011111: r = 5'h1B;
         7'b1001110: r = 5'h1C;
         7'b0111101: r = 5'h1D;
         7'b1001111: r = 5'h1E;
         7'b1000111: r = 5'h1F;
         default:    r = 5'h00;
      endcase
      return r;
   endfunction

   state_t                 state_r, state_s;
   logic [0:6]             s_q_r;
   logic [CNT_W-1:0]       cnt_r;
   logic [3:0]             mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
   logic [LVL_W-1:0]       level_r;
   logic                   err_pulse_r;
   logic [ERR_CNT_W-1:0]   err_count_r;
   logic                   overflow_r;

   logic                   diff_s, blank_s, commit_s, push_s, illegal_s;
   logic                   pop_s, full_s, write_s;
   logic [4:0]             dec_s;

   assign diff_s  = (seg_in != s_q_r);
   assign blank_s = (s_q_r == 7'b0000000);
   assign dec_s   = decode_glyph(s_q_r);

   // Sample register and saturating stability counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_q_r <= 7'b0000000;
         cnt_r <= CNT_W'(0);
      end else begin
         s_q_r <= seg_in;
         if (diff_s) begin
            cnt_r <= CNT_W'(1);
         end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state; a change on the commit edge still commits the settled glyph first.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (diff_s && (seg_in != 7'b0000000)) state_s = ST_SETTLE;
            else                                  state_s = ST_IDLE;
         end
         ST_SETTLE: begin
            if (diff_s)                 state_s = ST_SETTLE;
            else if (cnt_r == CNT_MAX)  state_s = blank_s ? ST_IDLE : ST_LOCKED;
            else                        state_s = ST_SETTLE;
         end
         ST_LOCKED: begin
            if (diff_s) state_s = ST_SETTLE;
            else        state_s = ST_LOCKED;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Commit decode: settled non-blank glyph becomes either a push or an error.
   always_comb begin
      commit_s  = 1'b0;
      push_s    = 1'b0;
      illegal_s = 1'b0;
      if ((state_r == ST_SETTLE) && (cnt_r == CNT_MAX)) commit_s = 1'b1;
      else                                              commit_s = 1'b0;
      if (commit_s && !blank_s) begin
         push_s    = dec_s[4];
         illegal_s = !dec_s[4];
      end else begin
         push_s    = 1'b0;
         illegal_s = 1'b0;
      end
   end

   assign pop_s   = (level_r != LVL_W'(0)) && dig.out_ready;
   assign full_s  = (level_r == LVL_FULL);
   assign write_s = push_s && (!full_s || pop_s);

   // Digit FIFO storage, pointers, level and sticky overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 4'h0;
         wr_ptr_r   <= PTR_W'(0);
         rd_ptr_r   <= PTR_W'(0);
         level_r    <= LVL_W'(0);
         overflow_r <= 1'b0;
      end else begin
         if (write_s) begin
            mem_r[wr_ptr_r] <= dec_s[3:0];
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         case ({write_s, pop_s})
            2'b10:   level_r <= level_r + LVL_W'(1);
            2'b01:   level_r <= level_r - LVL_W'(1);
            default: level_r <= level_r;
         endcase
         overflow_r <= overflow_r | (push_s && !write_s);
      end
   end

   // Illegal-glyph pulse and saturating counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_pulse_r <= 1'b0;
         err_count_r <= {ERR_CNT_W{1'b0}};
      end else begin
         err_pulse_r <= illegal_s;
         if (illegal_s && (err_count_r != ERR_MAX)) err_count_r <= err_count_r + ERR_CNT_W'(1);
         else                                       err_count_r <= err_count_r;
      end
   end

   assign dig.out_valid = (level_r != LVL_W'(0));
   assign dig.out_digit = mem_r[rd_ptr_r];
   assign fifo_level    = level_r;
   assign err_pulse     = err_pulse_r;
   assign err_count     = err_count_r;
   assign overflow      = overflow_r;

endmodule
